// File: rtl/led_code_pkg.sv
// Shared types for the LED blink-code scheduler: FSM states, index width helper
// and the blink-count type.
package led_code_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    localparam int N_REQ_DEF = 4;
    localparam int ID_W      = $clog2(N_REQ_DEF);

    // Blink counter is sized for the widest supported code field (CODE_W <= 8).
    localparam int BLINK_W = 8;
    typedef logic [BLINK_W-1:0] blink_cnt_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester select: combinational search from the pointer, plus a
// pointer register that moves past the winner when the grant is taken.
module rr_arbiter
    import led_code_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % N_REQ);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        grant_oh = grant_valid ? (N_REQ'(1) << grant_idx) : '0;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/led_code_scheduler.sv
// Shares one status LED between requesters: round-robin grant, then the owner's
// blink code as timed ON/OFF pulses and a trailing gap, ending with a done pulse.
module led_code_scheduler
    import led_code_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int CODE_W    = 4,
    parameter int CNT_W     = 16,
    parameter int ON_TICKS  = 125,
    parameter int OFF_TICKS = 125,
    parameter int GAP_TICKS = 500
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*CODE_W-1:0]   i_code,
    output logic [N_REQ-1:0]          o_grant,
    output logic [N_REQ-1:0]          o_done,
    output logic                      o_busy,
    output logic [$clog2(N_REQ)-1:0]  o_owner,
    output logic                      o_led_drive,
    output state_e                    o_dbg_state
);

    localparam int OWN_W = id_width(N_REQ);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    blink_cnt_t       blinks_q, blinks_d;
    logic [OWN_W-1:0] owner_q, owner_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done;

    logic [N_REQ-1:0]  arb_grant;
    logic [OWN_W-1:0]  arb_idx;
    logic              arb_valid;
    logic              advance;
    logic [CODE_W-1:0] sel_code;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (OWN_W)
    ) u_arb (
        .clk         (i_clock),
        .rst         (i_reset),
        .req         (i_req),
        .advance     (advance),
        .grant_oh    (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_comb begin
        sel_code = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (arb_idx == OWN_W'(k)) begin
                sel_code = i_code[k*CODE_W +: CODE_W];
            end
        end
    end

    // Each timed state loads TICKS-1 on entry and leaves on the cycle it reads 0.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        blinks_d = blinks_q;
        owner_d  = owner_q;
        grant_d  = '0;
        advance  = 1'b0;
        done     = '0;
        case (state_q)
            ST_IDLE: begin
                if (i_enable && arb_valid) begin
                    advance  = 1'b1;
                    grant_d  = arb_grant;
                    owner_d  = arb_idx;
                    blinks_d = blink_cnt_t'(sel_code);
                    if (sel_code != '0) begin
                        state_d = ST_ON;
                        tick_d  = CNT_W'(ON_TICKS - 1);
                    end else begin
                        state_d = ST_GAP;
                        tick_d  = CNT_W'(GAP_TICKS - 1);
                    end
                end
            end
            ST_ON: begin
                if (tick_q == '0) begin
                    blinks_d = blinks_q - blink_cnt_t'(1);
                    if (blinks_d != '0) begin
                        state_d = ST_OFF;
                        tick_d  = CNT_W'(OFF_TICKS - 1);
                    end else begin
                        state_d = ST_GAP;
                        tick_d  = CNT_W'(GAP_TICKS - 1);
                    end
                end else begin
                    tick_d = tick_q - CNT_W'(1);
                end
            end
            ST_OFF: begin
                if (tick_q == '0) begin
                    state_d = ST_ON;
                    tick_d  = CNT_W'(ON_TICKS - 1);
                end else begin
                    tick_d = tick_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (tick_q == '0) begin
                    done[owner_q] = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    tick_d = tick_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            tick_q   <= '0;
            blinks_q <= '0;
            owner_q  <= '0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            blinks_q <= blinks_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
        end
    end

    assign o_grant     = grant_q;
    assign o_done      = done;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_owner     = owner_q;
    assign o_led_drive = (state_q == ST_ON) & i_enable;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_led_code_scheduler.sv
// Self-checking bench for led_code_scheduler with short tick constants: a directed
// per-cycle table, hand-written corner sequences and a randomized phase.
module tb_led_code_scheduler;

    localparam int N    = 4;
    localparam int CW   = 4;
    localparam int ON   = 2;
    localparam int OFF  = 3;
    localparam int GAP  = 4;

    logic           i_clock = 1'b0;
    logic           i_reset;
    logic           i_enable;
    logic [N-1:0]   i_req;
    logic [N*CW-1:0] i_code;
    logic [N-1:0]   o_grant;
    logic [N-1:0]   o_done;
    logic           o_busy;
    logic [1:0]     o_owner;
    logic           o_led_drive;
    logic [1:0]     o_dbg_state;

    always #5 i_clock = ~i_clock;

    led_code_scheduler #(
        .N_REQ     (N),
        .CODE_W    (CW),
        .CNT_W     (8),
        .ON_TICKS  (ON),
        .OFF_TICKS (OFF),
        .GAP_TICKS (GAP)
    ) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_req       (i_req),
        .i_code      (i_code),
        .o_grant     (o_grant),
        .o_done      (o_done),
        .o_busy      (o_busy),
        .o_owner     (o_owner),
        .o_led_drive (o_led_drive),
        .o_dbg_state (o_dbg_state)
    );

    // Reference model: the owned sequence is a queue of per-cycle LED levels,
    // built at grant time from the code and consumed one entry per cycle.
    bit       seq[$];
    logic [N-1:0] m_grant;
    int       m_owner;
    int       m_ptr;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int grant_log[$];
    int led_hi_cnt;
    int done_cnt;
    int g_cyc;
    int d_cyc;
    logic         s_led;
    logic         s_busy;
    logic [N-1:0] s_grant;
    logic [N-1:0] s_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    endtask

    task automatic model_edge(input logic [N-1:0] req, input logic [N*CW-1:0] code,
                              input logic en, input logic rst);
        int w;
        int c;
        m_grant = '0;
        if (rst) begin
            seq.delete();
            m_ptr   = 0;
            m_owner = 0;
        end else if (seq.size() > 0) begin
            void'(seq.pop_front());
        end else if (en && (req != '0)) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            m_grant = N'(1) << w;
            m_owner = w;
            m_ptr   = (w + 1) % N;
            c = int'(code[w*CW +: CW]);
            for (int b = 0; b < c; b++) begin
                repeat (ON) seq.push_back(1'b1);
                if (b < c - 1) repeat (OFF) seq.push_back(1'b0);
            end
            repeat (GAP) seq.push_back(1'b0);
        end
    endtask

    task automatic cycle(input logic [N-1:0] req, input logic [N*CW-1:0] code,
                         input logic en, input logic rst);
        logic [N-1:0] exp_done;
        @(negedge i_clock);
        i_req    = req;
        i_code   = code;
        i_enable = en;
        i_reset  = rst;
        #1;
        exp_done = (seq.size() == 1) ? (N'(1) << m_owner) : '0;
        check("busy",  32'(o_busy), 32'(seq.size() > 0));
        check("led",   32'(o_led_drive), 32'((seq.size() > 0) && seq[0] && en));
        check("done",  32'(o_done), 32'(exp_done));
        check("grant", 32'(o_grant), 32'(m_grant));
        check("owner", 32'(o_owner), 32'(m_owner));
        s_led   = o_led_drive;
        s_busy  = o_busy;
        s_grant = o_grant;
        s_done  = o_done;
        if (o_grant != '0) begin
            grant_log.push_back(int'(o_owner));
            g_cyc = cyc;
        end
        if (o_led_drive) led_hi_cnt++;
        if (o_done != '0) begin
            done_cnt++;
            d_cyc = cyc;
        end
        @(posedge i_clock);
        model_edge(req, code, en, rst);
        cyc++;
    endtask

    task automatic drain();
        int n = 0;
        while (seq.size() > 0 && n < 200) begin
            cycle('0, '0, 1'b1, 1'b0);
            n++;
        end
        check("drain_bound", 32'(seq.size()), 32'd0);
        cycle('0, '0, 1'b1, 1'b0);
    endtask

    task automatic clear_stats();
        grant_log.delete();
        led_hi_cnt = 0;
        done_cnt   = 0;
        g_cyc      = -1;
        d_cyc      = -1;
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] grant;
        logic         led;
        logic         busy;
        logic [N-1:0] done;
    } vec_t;

    vec_t tbl[13];
    logic [N-1:0] r_req;

    initial begin
        // Single request, code 2: LED 1-2 and 6-7, done in cycle 11, idle in 12.
        tbl[0]  = '{4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000};
        tbl[1]  = '{4'b0000, 4'b0001, 1'b1, 1'b1, 4'b0000};
        tbl[2]  = '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000};
        tbl[3]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000};
        tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000};
        tbl[5]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000};
        tbl[6]  = '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000};
        tbl[7]  = '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000};
        tbl[8]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000};
        tbl[9]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000};
        tbl[10] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000};
        tbl[11] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0001};
        tbl[12] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000};

        seq.delete();
        m_grant  = '0;
        m_owner  = 0;
        m_ptr    = 0;
        i_reset  = 1'b1;
        i_enable = 1'b0;
        i_req    = '0;
        i_code   = '0;
        repeat (2) @(posedge i_clock);
        cycle('0, '0, 1'b1, 1'b1);
        clear_stats();

        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].req, 16'h0002, 1'b1, 1'b0);
            check($sformatf("tbl%0d_led", i),   32'(s_led),   32'(tbl[i].led));
            check($sformatf("tbl%0d_busy", i),  32'(s_busy),  32'(tbl[i].busy));
            check($sformatf("tbl%0d_grant", i), 32'(s_grant), 32'(tbl[i].grant));
            check($sformatf("tbl%0d_done", i),  32'(s_done),  32'(tbl[i].done));
        end

        // Round robin with all four requesting and all codes 1.
        cycle('0, '0, 1'b1, 1'b1);
        clear_stats();
        repeat (35) cycle(4'b1111, 16'h1111, 1'b1, 1'b0);
        drain();
        check("rr_count", 32'(grant_log.size()), 32'd5);
        if (grant_log.size() == 5) begin
            check("rr_0", 32'(grant_log[0]), 32'd0);
            check("rr_1", 32'(grant_log[1]), 32'd1);
            check("rr_2", 32'(grant_log[2]), 32'd2);
            check("rr_3", 32'(grant_log[3]), 32'd3);
            check("rr_4", 32'(grant_log[4]), 32'd0);
        end

        // Zero code: grant, no LED, done in the fourth GAP cycle counting the grant cycle.
        clear_stats();
        cycle(4'b0100, 16'h0000, 1'b1, 1'b0);
        repeat (6) cycle('0, 16'h0000, 1'b1, 1'b0);
        check("zero_grant_n", 32'(grant_log.size()), 32'd1);
        if (grant_log.size() == 1) check("zero_grant_id", 32'(grant_log[0]), 32'd2);
        check("zero_led", 32'(led_hi_cnt), 32'd0);
        check("zero_done_n", 32'(done_cnt), 32'd1);
        check("zero_done_lat", 32'(d_cyc - g_cyc), 32'(GAP - 1));

        // Reset during the second ON of a code-3 sequence; req0 then wins first.
        clear_stats();
        cycle(4'b0010, 16'h0030, 1'b1, 1'b0);
        repeat (5) cycle(4'b1001, 16'h0030, 1'b1, 1'b0);
        cycle(4'b1001, 16'h0030, 1'b1, 1'b1);
        check("rst_led_before", 32'(s_led), 32'd1);
        grant_log.delete();
        cycle(4'b1001, 16'h0030, 1'b1, 1'b0);
        check("rst_idle_busy", 32'(s_busy), 32'd0);
        check("rst_idle_led", 32'(s_led), 32'd0);
        check("rst_no_done", 32'(done_cnt), 32'd0);
        cycle(4'b0000, 16'h0030, 1'b1, 1'b0);
        check("rst_first_grant_n", 32'(grant_log.size()), 32'd1);
        if (grant_log.size() >= 1) check("rst_first_grant", 32'(grant_log[0]), 32'd0);
        drain();

        // Enable low blocks grants; dropping it mid-ON darkens the LED only.
        clear_stats();
        repeat (5) cycle(4'b0100, 16'h0200, 1'b0, 1'b0);
        check("en_blocked", 32'(grant_log.size()), 32'd0);
        cycle(4'b0100, 16'h0200, 1'b1, 1'b0);
        cycle('0, 16'h0200, 1'b1, 1'b0);
        cycle('0, 16'h0200, 1'b0, 1'b0);
        check("en_led_masked", 32'(s_led), 32'd0);
        check("en_busy_kept", 32'(s_busy), 32'd1);
        drain();
        check("en_done_n", 32'(done_cnt), 32'd1);
        check("en_done_lat", 32'(d_cyc - g_cyc), 32'(2*ON + OFF + GAP - 1));

        // Code changed after grant: the latched count of 3 still plays out.
        clear_stats();
        cycle(4'b0001, 16'h0003, 1'b1, 1'b0);
        repeat (3) cycle('0, 16'h0001, 1'b1, 1'b0);
        drain();
        check("code_latch_led", 32'(led_hi_cnt), 32'(3*ON));

        // Randomized phase: requests come, linger or drop; enable and reset glitch.
        r_req = '0;
        for (int i = 0; i < 400; i++) begin
            logic [N*CW-1:0] rc;
            logic            ren;
            logic            rrst;
            for (int b = 0; b < N; b++) begin
                if (r_req[b]) begin
                    if ($urandom_range(0, 19) == 0) r_req[b] = 1'b0;
                end else if ($urandom_range(0, 9) == 0) begin
                    r_req[b] = 1'b1;
                end
            end
            for (int b = 0; b < N; b++) rc[b*CW +: CW] = CW'($urandom_range(0, 3));
            ren  = ($urandom_range(0, 19) != 0);
            rrst = ($urandom_range(0, 199) == 0);
            cycle(r_req, rc, ren, rrst);
            r_req = r_req & ~m_grant;
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
